// File: rtl/qnigma_retx_ctrl.sv
// qnigma_retx_ctrl -- send / wait-for-ack / retransmit controller.
//
// A transaction starts with one send pulse, then waits for ack while an
// upstream timer delivers ticks. After TIMEOUT_TICKS ticks without ack the
// request is retransmitted, up to MAX_RETRIES times; one more timeout after
// that ends the transaction with fail. ack ends it with done. abort cancels
// it silently.
//
// Parameters:
//   TIMEOUT_TICKS  timer ticks per attempt before timeout (>= 1)
//   MAX_RETRIES    retransmissions after the first send (>= 0)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a transaction (honoured only when idle)
//   ack        response received for the current transaction
//   abort      cancel any transaction in progress
//   tick       timer tick from the upstream timer
//   tmr_en     upstream timer enable (high while waiting)
//   tmr_rst    upstream timer clear (high while sending)
//   send       one-cycle transmit / retransmit request
//   done       one-cycle success pulse
//   fail       one-cycle failure pulse
//   busy       high whenever not idle
//   retry_cnt  retransmissions issued in the current or last transaction
module qnigma_retx_ctrl #(
    parameter int TIMEOUT_TICKS = 4,
    parameter int MAX_RETRIES   = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ack,
    input  logic          abort,
    input  logic          tick,
    output logic          tmr_en,
    output logic          tmr_rst,
    output logic          send,
    output logic          done,
    output logic          fail,
    output logic          busy,
    output logic [RW-1:0] retry_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    state_t        state, state_n;
    logic [RW-1:0] retry_q, retry_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic          done_q, done_n;
    logic          fail_q, fail_n;

    // State register. done/fail are registered so they appear in the cycle
    // after the deciding event, already in IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            retry_q <= '0;
            tcnt_q  <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state   <= state_n;
            retry_q <= retry_n;
            tcnt_q  <= tcnt_n;
            done_q  <= done_n;
            fail_q  <= fail_n;
        end
    end

    // Next-state logic. Priority: abort > ack > timeout/tick > start.
    always_comb begin
        // NOTE: every target gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_n = state;
        retry_n = retry_q;
        tcnt_n  = tcnt_q;
        done_n  = 1'b0;
        fail_n  = 1'b0;

        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n = SEND;
                        retry_n = '0;
                        tcnt_n  = '0;
                    end
                end
                SEND: begin
                    tcnt_n = '0;
                    if (ack) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else if (tick) begin
                        if (tcnt_q == TCNT_LAST) begin
                            // Retry budget check; retry_cnt only increments
                            // below the limit, so it saturates instead of wrapping.
                            if (retry_q < RETRY_MAX) begin
                                retry_n = retry_q + RW'(1);
                                state_n = SEND;
                            end else begin
                                state_n = IDLE;
                                fail_n  = 1'b1;
                            end
                        end else begin
                            tcnt_n = tcnt_q + TW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        send      = (state == SEND);
        tmr_rst   = (state == SEND);
        tmr_en    = (state == WAIT);
        busy      = (state != IDLE);
        done      = done_q;
        fail      = fail_q;
        retry_cnt = retry_q;
    end

endmodule

// File: tb/tb_qnigma_retx_ctrl.sv
// Directed self-checking bench for qnigma_retx_ctrl (TIMEOUT_TICKS=3,
// MAX_RETRIES=2), plus a second instance with TIMEOUT_TICKS=1,
// MAX_RETRIES=0 for the no-retry boundary.
module tb_qnigma_retx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, ack, abort, tick;
    logic       tmr_en, tmr_rst, send, done, fail, busy;
    logic [1:0] retry_cnt;

    logic       start0, tick0, ack0, abort0;
    logic       tmr_en0, tmr_rst0, send0, done0, fail0, busy0;
    logic [0:0] retry0;

    int n_tests = 0;
    int n_fail  = 0;
    int excl_viol = 0;
    logic send_d = 1'b0, done_d = 1'b0, fail_d = 1'b0;

    always #5 clk = ~clk;

    qnigma_retx_ctrl #(.TIMEOUT_TICKS(3), .MAX_RETRIES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .abort(abort),
        .tick(tick), .tmr_en(tmr_en), .tmr_rst(tmr_rst), .send(send),
        .done(done), .fail(fail), .busy(busy), .retry_cnt(retry_cnt)
    );

    qnigma_retx_ctrl #(.TIMEOUT_TICKS(1), .MAX_RETRIES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .ack(ack0), .abort(abort0),
        .tick(tick0), .tmr_en(tmr_en0), .tmr_rst(tmr_rst0), .send(send0),
        .done(done0), .fail(fail0), .busy(busy0), .retry_cnt(retry0)
    );

    // Pulse outputs must be mutually exclusive and never high two cycles running.
    always @(negedge clk) begin
        if (int'(send) + int'(done) + int'(fail) > 1) excl_viol++;
        if ((send && send_d) || (done && done_d) || (fail && fail_d)) excl_viol++;
        send_d <= send;
        done_d <= done;
        fail_d <= fail;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from start. Ticks arrive every `period` cycles;
    // ack is raised together with effective tick number ack_at (0 = never).
    task automatic run_txn(input int period, input int ack_at,
                           output int n_send, output int n_tick,
                           output int n_done, output int n_fl);
        n_send = 0; n_tick = 0; n_done = 0; n_fl = 0;
        for (int i = 0; i < 200; i++) begin
            start = (i == 0);
            tick  = (i % period == period - 1);
            ack   = 1'b0;
            if (tick && tmr_en) begin
                n_tick++;
                if (n_tick == ack_at) ack = 1'b1;
            end
            cyc();
            if (send) begin
                check("retry_at_send", int'(retry_cnt), n_send);
                check("ticks_at_send", n_tick, n_send * 3);
                n_send++;
            end
            if (done) n_done++;
            if (fail) n_fl++;
            if (done || fail) break;
        end
        start = 1'b0; tick = 1'b0; ack = 1'b0;
        check("txn_ended", n_done + n_fl, 1);
    endtask

    int ns, nt, nd, nf;

    initial begin
        rst_n = 1'b0;
        start = 0; ack = 0; abort = 0; tick = 0;
        start0 = 0; tick0 = 0; ack0 = 0; abort0 = 0;

        // Reset state, before any clock edge.
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_send", int'(send), 0);
        check("rst_outs", int'({tmr_en, tmr_rst, done, fail}), 0);
        check("rst_retry", int'(retry_cnt), 0);
        @(negedge clk) rst_n = 1'b1;

        // First start on the first edge after release; ack two cycles after send.
        start = 1'b1; cyc(); start = 1'b0;
        check("t1_send", int'(send), 1);
        check("t1_tmr_rst", int'(tmr_rst), 1);
        check("t1_tmr_en_in_send", int'(tmr_en), 0);
        cyc();
        check("t1_wait_send", int'(send), 0);
        check("t1_wait_tmr_en", int'(tmr_en), 1);
        check("t1_wait_tmr_rst", int'(tmr_rst), 0);
        cyc();
        ack = 1'b1; cyc(); ack = 1'b0;
        check("t1_done", int'(done), 1);
        check("t1_busy", int'(busy), 0);
        check("t1_retry", int'(retry_cnt), 0);
        cyc();
        check("t1_done_once", int'(done), 0);

        // ack while idle is ignored.
        ack = 1'b1; cyc(); ack = 1'b0;
        check("idle_ack_done", int'(done), 0);
        check("idle_ack_busy", int'(busy), 0);

        // No ack, tick every 2 cycles: three sends, fail after the 9th tick.
        run_txn(2, 0, ns, nt, nd, nf);
        check("t2_sends", ns, 3);
        check("t2_ticks", nt, 9);
        check("t2_fail", nf, 1);
        check("t2_done", nd, 0);
        check("t2_fail_busy", int'(busy), 0);
        cyc();
        check("t2_fail_once", int'(fail), 0);
        check("t2_retry_hold", int'(retry_cnt), 2);

        // ack together with the final timeout tick: done wins, no 4th send.
        run_txn(1, 9, ns, nt, nd, nf);
        check("t3_done", nd, 1);
        check("t3_fail", nf, 0);
        check("t3_sends", ns, 3);
        tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t3_no_send", int'(send), 0);
            check("t3_no_fail", int'(fail), 0);
        end
        tick = 1'b0;

        // Abort after one tick in WAIT; start while busy is ignored.
        start = 1'b1; cyc(); start = 1'b0;
        check("t4_retry_clr", int'(retry_cnt), 0);
        cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check("t4_busy_start_send", int'(send), 0);
        check("t4_busy_start_wait", int'(tmr_en), 1);
        abort = 1'b1; cyc(); abort = 1'b0;
        check("t4_abort_busy", int'(busy), 0);
        check("t4_abort_tmr_en", int'(tmr_en), 0);
        check("t4_abort_df", int'({done, fail}), 0);
        cyc();
        check("t4_after_df", int'({done, fail}), 0);

        // abort beats a same-cycle ack.
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        ack = 1'b1; abort = 1'b1; cyc(); ack = 1'b0; abort = 1'b0;
        check("t5_abort_ack_done", int'(done), 0);
        check("t5_abort_ack_busy", int'(busy), 0);
        cyc();
        check("t5_after_done", int'(done), 0);

        // Reset mid-WAIT with retry_cnt=1.
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        tick = 1'b0;
        check("t6_pre_wait", int'(tmr_en), 1);
        check("t6_pre_retry", int'(retry_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_tmr_en", int'(tmr_en), 0);
        check("t6_rst_retry", int'(retry_cnt), 0);
        check("t6_rst_pulses", int'({send, done, fail, tmr_rst}), 0);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        check("t6_post_df", int'({done, fail}), 0);
        start = 1'b1; cyc(); start = 1'b0;
        check("t6_restart_send", int'(send), 1);
        check("t6_restart_retry", int'(retry_cnt), 0);
        cyc(); cyc();
        abort = 1'b1; cyc(); abort = 1'b0;

        // MAX_RETRIES=0, TIMEOUT_TICKS=1: first timeout fails, no retransmit.
        start0 = 1'b1; cyc(); start0 = 1'b0;
        check("m0_send", int'(send0), 1);
        cyc();
        check("m0_wait", int'(tmr_en0), 1);
        tick0 = 1'b1; cyc(); tick0 = 1'b0;
        check("m0_fail", int'(fail0), 1);
        check("m0_no_resend", int'(send0), 0);
        check("m0_busy", int'(busy0), 0);
        check("m0_retry", int'(retry0), 0);

        cyc();
        check("pulse_exclusive", excl_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
